// File: rtl/control_sequencer.sv
// Multi-cycle control unit: fetch/decode/execute sequencer with datapath selects.
// Optional memory-wait timeout and FAULT state enabled by CU_MEM_TIMEOUT_EN.
module control_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ir,
    input  logic        cond_true,
    input  logic        moc,
    output logic [1:0]  MA,
    output logic [1:0]  MB,
    output logic [2:0]  MC,
    output logic        MD,
    output logic        ME,
    output logic [1:0]  MF,
    output logic        MG,
    output logic [1:0]  MJ,
    output logic [4:0]  OP,
    output logic        RFLd,
    output logic        IRLd,
    output logic        MARLd,
    output logic        MDRLd,
    output logic        FlagLd,
    output logic        MOV,
    output logic        RW,
    output logic        fault
);

    localparam logic [4:0] OP_ADD   = 5'b00100;
    localparam logic [4:0] OP_SUB   = 5'b00010;
    localparam logic [4:0] OP_PASSA = 5'b10000;

    typedef enum logic [3:0] {
        IDLE, FETCH0, FETCH1, FETCH2, DECODE, DP, LS_ADDR,
        ST_DATA, ST_WAIT, LD_WAIT, LD_WB, BL_LINK, BR_TGT, FAULT
    } state_t;

    state_t state, nxt;

    logic unused_ir;
    assign unused_ir = ^{ir[31:28], ir[22:21], ir[19:0]};

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    nxt = FETCH0;
            FETCH0:  nxt = FETCH1;
            FETCH1:  nxt = moc ? FETCH2 : FETCH1;
            FETCH2:  nxt = DECODE;
            DECODE: begin
                if (!cond_true)             nxt = FETCH0;
                else if (ir[27:26] == 2'b00)  nxt = DP;
                else if (ir[27:25] == 3'b010) nxt = LS_ADDR;
                else if (ir[27:25] == 3'b101) nxt = ir[24] ? BL_LINK : BR_TGT;
                else                        nxt = FETCH0;
            end
            DP:      nxt = FETCH0;
            LS_ADDR: nxt = ir[20] ? LD_WAIT : ST_DATA;
            ST_DATA: nxt = ST_WAIT;
            ST_WAIT: nxt = moc ? FETCH0 : ST_WAIT;
            LD_WAIT: nxt = moc ? LD_WB : LD_WAIT;
            LD_WB:   nxt = FETCH0;
            BL_LINK: nxt = BR_TGT;
            BR_TGT:  nxt = FETCH0;
            FAULT:   nxt = FAULT;
            default: nxt = IDLE;
        endcase
    end

`ifdef CU_MEM_TIMEOUT_EN
    logic [3:0] tcnt;
    logic       waiting;
    assign waiting = (state == FETCH1) || (state == LD_WAIT) || (state == ST_WAIT);

    // 16th consecutive cycle without moc abandons the access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            tcnt  <= 4'd0;
        end else if (waiting && !moc) begin
            if (tcnt == 4'hf) begin
                state <= FAULT;
                tcnt  <= 4'd0;
            end else begin
                state <= nxt;
                tcnt  <= tcnt + 4'd1;
            end
        end else begin
            state <= nxt;
            tcnt  <= 4'd0;
        end
    end

    assign fault = (state == FAULT);
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    assign fault = 1'b0;
`endif

    always_comb begin
        MA = 2'd0; MB = 2'd0; MC = 3'd0; MD = 1'b0;
        ME = 1'b0; MF = 2'd0; MG = 1'b0; MJ = 2'd0;
        OP = 5'd0; RFLd = 1'b0; IRLd = 1'b0; MARLd = 1'b0;
        MDRLd = 1'b0; FlagLd = 1'b0; MOV = 1'b0; RW = 1'b0;
        unique case (state)
            FETCH0: begin
                MA = 2'd2; MD = 1'b1; OP = OP_PASSA; MARLd = 1'b1;
            end
            FETCH1: begin
                MOV = 1'b1; RW = 1'b1; IRLd = moc;
            end
            FETCH2: begin
                MA = 2'd2; MB = 2'd2; MD = 1'b1; OP = OP_ADD;
                MC = 3'd3; RFLd = 1'b1;
            end
            DP: begin
                MB = 2'd1; FlagLd = ir[20];
                RFLd = (ir[24:23] != 2'b10);
            end
            LS_ADDR: begin
                MD = 1'b1; MARLd = 1'b1;
                OP = ir[23] ? OP_ADD : OP_SUB;
            end
            ST_DATA: begin
                MJ = 2'd2; MDRLd = 1'b1;
            end
            ST_WAIT: MOV = 1'b1;
            LD_WAIT: begin
                MOV = 1'b1; RW = 1'b1; ME = 1'b1; MDRLd = moc;
            end
            LD_WB: begin
                MF = 2'd1; RFLd = 1'b1;
            end
            BL_LINK: begin
                MA = 2'd2; MD = 1'b1; OP = OP_PASSA;
                MC = 3'd2; RFLd = 1'b1;
            end
            BR_TGT: begin
                MA = 2'd2; MG = 1'b1; MD = 1'b1; OP = OP_ADD;
                MC = 3'd3; RFLd = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: per-cycle expected output vectors.
// Build with +define+CU_MEM_TIMEOUT_EN to exercise the timeout fault path.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ir;
    logic        cond_true;
    logic        moc;
    logic [1:0]  MA, MB, MF, MJ;
    logic [2:0]  MC;
    logic        MD, ME, MG;
    logic [4:0]  OP;
    logic        RFLd, IRLd, MARLd, MDRLd, FlagLd, MOV, RW, fault;

    control_sequencer dut (
        .clk(clk), .rst_n(rst_n), .ir(ir), .cond_true(cond_true), .moc(moc),
        .MA(MA), .MB(MB), .MC(MC), .MD(MD), .ME(ME), .MF(MF), .MG(MG), .MJ(MJ),
        .OP(OP), .RFLd(RFLd), .IRLd(IRLd), .MARLd(MARLd), .MDRLd(MDRLd),
        .FlagLd(FlagLd), .MOV(MOV), .RW(RW), .fault(fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [26:0] exp;
        string       name;
    } item_t;

    item_t q[$];
    int    checks = 0;
    int    errors = 0;

    logic [26:0] act;
    assign act = {MA, MB, MC, MD, ME, MF, MG, MJ, OP,
                  RFLd, IRLd, MARLd, MDRLd, FlagLd, MOV, RW, fault};

    // ma mb mc md me mf mg mj op rfld irld marld mdrld flagld mov rw fault
    function automatic logic [26:0] ev(
        input int ma, input int mb, input int mc, input int md,
        input int me, input int mf, input int mg, input int mj,
        input int op, input int rf, input int irl, input int mar,
        input int mdr, input int fl, input int mov, input int rw,
        input int flt);
        logic [26:0] v;
        v = {ma[1:0], mb[1:0], mc[2:0], md[0], me[0], mf[1:0], mg[0],
             mj[1:0], op[4:0], rf[0], irl[0], mar[0], mdr[0], fl[0],
             mov[0], rw[0], flt[0]};
        return v;
    endfunction

    logic [26:0] F0, F1_0, F1_1, F2, DPADD, DPCMP, LSU, LSS;
    logic [26:0] LDW0, LDW1, LDWB, STD, STW, BLL, BRT, FLT;

    always @(negedge clk) begin
        if (q.size() > 0) begin
            item_t it;
            it = q.pop_front();
            checks++;
            if (act !== it.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", it.name, act, it.exp);
            end
        end
    end

    task automatic cyc(input string nm, input logic [26:0] e);
        item_t it;
        it.exp  = e;
        it.name = nm;
        q.push_back(it);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] v, input logic c);
        ir        = v;
        cond_true = c;
        moc       = 1'b1;
        cyc("fetch0", F0);
        cyc("fetch1_moc", F1_1);
        moc = 1'b0;
        cyc("fetch2", F2);
        cyc("decode", 27'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        F0    = ev(2,0,0,1,0,0,0,0,16,0,0,1,0,0,0,0,0);
        F1_0  = ev(0,0,0,0,0,0,0,0, 0,0,0,0,0,0,1,1,0);
        F1_1  = ev(0,0,0,0,0,0,0,0, 0,0,1,0,0,0,1,1,0);
        F2    = ev(2,2,3,1,0,0,0,0, 4,1,0,0,0,0,0,0,0);
        DPADD = ev(0,1,0,0,0,0,0,0, 0,1,0,0,0,0,0,0,0);
        DPCMP = ev(0,1,0,0,0,0,0,0, 0,0,0,0,0,1,0,0,0);
        LSU   = ev(0,0,0,1,0,0,0,0, 4,0,0,1,0,0,0,0,0);
        LSS   = ev(0,0,0,1,0,0,0,0, 2,0,0,1,0,0,0,0,0);
        LDW0  = ev(0,0,0,0,1,0,0,0, 0,0,0,0,0,0,1,1,0);
        LDW1  = ev(0,0,0,0,1,0,0,0, 0,0,0,0,1,0,1,1,0);
        LDWB  = ev(0,0,0,0,0,1,0,0, 0,1,0,0,0,0,0,0,0);
        STD   = ev(0,0,0,0,0,0,0,2, 0,0,0,0,1,0,0,0,0);
        STW   = ev(0,0,0,0,0,0,0,0, 0,0,0,0,0,0,1,0,0);
        BLL   = ev(2,0,2,1,0,0,0,0,16,1,0,0,0,0,0,0,0);
        BRT   = ev(2,0,3,1,0,0,1,0, 4,1,0,0,0,0,0,0,0);
        FLT   = ev(0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,1);

        rst_n = 1'b0; ir = 32'd0; cond_true = 1'b0; moc = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        cyc("reset", 27'd0);
        rst_n = 1'b1;
        cyc("idle", 27'd0);

        // fetch with moc arriving on the second FETCH1 cycle
        ir = 32'hE0812003; cond_true = 1'b1; moc = 1'b0;
        cyc("fetch0", F0);
        cyc("fetch1_wait", F1_0);
        moc = 1'b1;
        cyc("fetch1_moc", F1_1);
        moc = 1'b0;
        cyc("fetch2", F2);
        cyc("decode", 27'd0);
        cyc("dp_add", DPADD);

        fetch(32'hE1500001, 1'b1);
        cyc("dp_cmp", DPCMP);

        fetch(32'hE5912004, 1'b1);
        cyc("ldr_addr", LSU);
        cyc("ld_wait0", LDW0);
        cyc("ld_wait1", LDW0);
        moc = 1'b1;
        cyc("ld_wait_moc", LDW1);
        moc = 1'b0;
        cyc("ld_wb", LDWB);

        fetch(32'hEB000010, 1'b1);
        cyc("bl_link", BLL);
        cyc("br_tgt", BRT);

        fetch(32'h0A000010, 1'b0);
        fetch(32'hEC000000, 1'b1);

        // STR, reset pulsed while the write is outstanding
        fetch(32'hE5012004, 1'b1);
        cyc("str_addr", LSS);
        cyc("st_data", STD);
        cyc("st_wait0", STW);
        cyc("st_wait1", STW);
        rst_n = 1'b0;
        cyc("rst_midwait", 27'd0);
        rst_n = 1'b1;
        cyc("idle2", 27'd0);

        // memory never answers the fetch
        ir = 32'hE0812003; moc = 1'b0;
        cyc("fetch0_to", F0);
        for (int i = 0; i < 16; i++) cyc("fetch1_hold", F1_0);
`ifdef CU_MEM_TIMEOUT_EN
        cyc("fault", FLT);
        moc = 1'b1;
        cyc("fault_hold0", FLT);
        cyc("fault_hold1", FLT);
        rst_n = 1'b0;
        cyc("fault_reset", 27'd0);
        rst_n = 1'b1;
        moc = 1'b0;
        cyc("idle3", 27'd0);
        cyc("fetch0_after", F0);
`else
        for (int i = 0; i < 4; i++) cyc("fetch1_hold_more", F1_0);
        moc = 1'b1;
        cyc("fetch1_late_moc", F1_1);
        moc = 1'b0;
        cyc("fetch2_late", F2);
`endif

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL have port clk, input, 1, single rising-edge clock.
REQ-002 The block SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-003 The block SHALL have port ir, input, 32, instruction register contents.
REQ-004 The block SHALL have port cond_true, input, 1, condition-tester result for ir[31:28].
REQ-005 The block SHALL have port moc, input, 1, memory operation complete.
REQ-006 The block SHALL have ports MA[2], MB[2], MC[3], MD[1], ME[1], MF[2], MG[1], MJ[2], all outputs, datapath mux selects.
REQ-007 The block SHALL have port OP, output, 5, ALU operation: ADD=00100, SUB=00010, PASSA=10000.
REQ-008 The block SHALL have ports RFLd, IRLd, MARLd, MDRLd, FlagLd, output, 1 each, register load enables.
REQ-009 The block SHALL have port MOV, output, 1, memory operation valid.
REQ-010 The block SHALL have port RW, output, 1, memory direction: 1=read, 0=write.
REQ-011 The block SHALL have port fault, output, 1, memory timeout fault flag.

Function
REQ-020 Moore FSM, one state per clk; outputs SHALL be decoded from the state register, plus ir for DP and LS_ADDR; unlisted outputs are 0.
REQ-021 IDLE: all outputs 0 -> FETCH0.
REQ-022 FETCH0: MA=2, MD=1, OP=PASSA, MARLd=1 -> FETCH1.
REQ-023 FETCH1: MOV=1, RW=1, IRLd=moc; hold while moc=0; moc=1 -> FETCH2.
REQ-024 FETCH2: MA=2, MB=2 (constant 4), MD=1, OP=ADD, MC=3, RFLd=1 -> DECODE.
REQ-025 DECODE transitions, no loads:
  - cond_true=0 -> FETCH0
  - ir[27:26]=00 -> DP
  - ir[27:25]=010 -> LS_ADDR
  - ir[27:25]=101 -> BL_LINK if ir[24], else BR_TGT
  - any other encoding -> FETCH0 (NOP)
REQ-026 DP: MA=0, MB=1, MD=0, MC=0, FlagLd=ir[20], RFLd=0 when ir[24:23]=10 else 1 -> FETCH0.
REQ-027 LS_ADDR: MA=0, MB=0, MD=1, OP=ADD if ir[23] else SUB, MARLd=1 -> LD_WAIT if ir[20], else ST_DATA.
REQ-028 ST_DATA: MJ=2, ME=0, MDRLd=1 -> ST_WAIT.
REQ-029 ST_WAIT: MOV=1, RW=0; hold until moc=1 -> FETCH0.
REQ-030 LD_WAIT: MOV=1, RW=1, ME=1, MDRLd=moc; moc=1 -> LD_WB.
REQ-031 LD_WB: MF=1, MC=0, RFLd=1 -> FETCH0.
REQ-032 BL_LINK: MA=2, MD=1, OP=PASSA, MC=2 (R14), RFLd=1 -> BR_TGT.
REQ-033 BR_TGT: MA=2, MG=1, MD=1, OP=ADD, MC=3, RFLd=1 -> FETCH0.
REQ-034 Wait states SHALL ignore ir and cond_true; moc outside wait states SHALL be ignored.
REQ-035 MOV SHALL stay high continuously from wait-state entry to the cycle moc is sampled high.

Reset
REQ-040 rst_n=0 SHALL force IDLE, clear the timeout counter and fault, and drive all outputs to 0 immediately, including mid-wait with MOV high.
REQ-041 After rst_n deasserts, first rising edge SHALL enter FETCH0.

Configuration
REQ-050 Macro CU_MEM_TIMEOUT_EN defined: a 4-bit counter SHALL increment each cycle in FETCH1, LD_WAIT and ST_WAIT while moc=0, and clear on wait-state exit.
REQ-051 With CU_MEM_TIMEOUT_EN defined, the 16th consecutive moc=0 cycle SHALL enter FAULT; FAULT drives fault=1, all other outputs 0, and holds until reset.
REQ-052 CU_MEM_TIMEOUT_EN undefined: wait states SHALL hold indefinitely; fault tied 0; no counter logic.

Verification
REQ-060 Reset release, moc=1 on the second FETCH1 cycle -> FETCH0, FETCH1, FETCH1, FETCH2, DECODE; IRLd=1 only on the moc cycle.
REQ-061 ir=0xE0812003 (ADD, S=0) -> DP: MD=0, RFLd=1, FlagLd=0; ir=0xE1500001 (CMP) -> RFLd=0, FlagLd=1.
REQ-062 ir=0xE5912004 (LDR, U=1) -> LS_ADDR OP=00100; moc after 3 cycles -> LD_WB MF=1, RFLd=1.
REQ-063 ir=0xEB000010 (BL) -> BL_LINK MC=2, then BR_TGT MC=3, MG=1; ir=0x0A000010 with cond_true=0 -> DECODE then FETCH0, no RFLd.
REQ-064 STR, rst_n pulsed low during ST_WAIT -> MOV=0 in the same cycle; restart at FETCH0.
REQ-065 With CU_MEM_TIMEOUT_EN, moc held 0 in FETCH1 -> fault=1 after 16 cycles, held until rst_n=0.
